// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM state encoding and
// bit positions of the per-register control bundle.
package pipeline_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_RUN      = 3'd1,
        ST_MEM_WAIT = 3'd2,
        ST_HALT     = 3'd3,
        ST_STEP     = 3'd4
    } state_e;

    localparam int unsigned CTL_STALL_IF  = 0;
    localparam int unsigned CTL_STALL_ID  = 1;
    localparam int unsigned CTL_STALL_EX  = 2;
    localparam int unsigned CTL_STALL_MEM = 3;
    localparam int unsigned CTL_FLUSH_IF  = 4;
    localparam int unsigned CTL_FLUSH_ID  = 5;
    localparam int unsigned CTL_W         = 6;

    localparam logic [CTL_W-1:0] CTL_ALL_STALL = 6'b00_1111;
    localparam logic [CTL_W-1:0] CTL_ALL_FLUSH = 6'b11_0000;

    localparam int unsigned WAIT_W = 8;

    // Cycles spent in INIT or HALT are not counted as executed cycles.
    function automatic logic is_active(input state_e s);
        return (s != ST_HALT) && (s != ST_INIT);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_perf_counter.sv
// Saturating up-counter used for the cycle and stall performance counters.
module pipeline_ctrl_perf_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            o_cnt <= '0;
        end else if (i_inc && (o_cnt != '1)) begin
            o_cnt <= o_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: resolves hazards,
// memory waits and debug run/step/halt into per-register hold/clear controls.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned INIT_FLUSH  = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load_use_hazard,
    input  logic             pc_change_EX,
    input  logic             mem_req_MEM,
    input  logic             mem_ready,
    input  logic             run,
    input  logic             step,
    output logic             stall_IF,
    output logic             stall_ID,
    output logic             stall_EX,
    output logic             stall_MEM,
    output logic             flush_IF,
    output logic             flush_ID,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned INIT_LAST  = (INIT_FLUSH > 0) ? INIT_FLUSH - 1 : 0;
    localparam int unsigned INIT_CNT_W = (INIT_LAST > 0) ? $clog2(INIT_LAST + 1) : 1;
    localparam logic [WAIT_W:0] TIMEOUT_LIM = (WAIT_W + 1)'(MEM_TIMEOUT);

    state_e                  r_state;
    state_e                  w_next;
    logic [WAIT_W-1:0]       r_wait;
    logic [INIT_CNT_W-1:0]   r_init_cnt;
    logic                    r_timeout;
    logic [CTL_W-1:0]        w_ctrl;
    logic                    w_halted;
    logic                    w_wait_clr;
    logic                    w_set_timeout;
    logic [WAIT_W:0]         w_wait_nxt;
    logic                    w_cycle_inc;
    logic                    w_stall_inc;

    assign w_wait_nxt = {1'b0, r_wait} + (WAIT_W + 1)'(1);

    // Next state and same-cycle control outputs.
    always_comb begin
        w_next        = r_state;
        w_ctrl        = '0;
        w_halted      = 1'b0;
        w_wait_clr    = 1'b0;
        w_set_timeout = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_ctrl = CTL_ALL_FLUSH;
                if (r_init_cnt >= INIT_CNT_W'(INIT_LAST)) begin
                    w_next = run ? ST_RUN : ST_HALT;
                end
            end
            ST_RUN, ST_STEP: begin
                if (mem_req_MEM && !mem_ready) begin
                    w_ctrl     = CTL_ALL_STALL;
                    w_wait_clr = 1'b1;
                    w_next     = ST_MEM_WAIT;
                end else begin
                    // A redirect squashes the load-use consumer, so it wins.
                    if (pc_change_EX) begin
                        w_ctrl = CTL_ALL_FLUSH;
                    end else if (load_use_hazard) begin
                        w_ctrl[CTL_STALL_IF] = 1'b1;
                        w_ctrl[CTL_FLUSH_ID] = 1'b1;
                    end
                    w_next = ((r_state == ST_STEP) || !run) ? ST_HALT : ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                w_ctrl = CTL_ALL_STALL;
                if (mem_ready) begin
                    w_next = run ? ST_RUN : ST_HALT;
                end else if ((MEM_TIMEOUT != 0) && (w_wait_nxt >= TIMEOUT_LIM)) begin
                    w_set_timeout = 1'b1;
                    w_next        = ST_HALT;
                end
            end
            ST_HALT: begin
                w_ctrl   = CTL_ALL_STALL;
                w_halted = 1'b1;
                if (run) begin
                    if (!r_timeout) begin
                        w_next = ST_RUN;
                    end
                end else if (step) begin
                    w_next = ST_STEP;
                end
            end
            default: begin
                w_next = ST_INIT;
            end
        endcase
        if (!rstn) begin
            w_ctrl   = '1;
            w_halted = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= ST_INIT;
            r_wait     <= '0;
            r_init_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_wait_clr) begin
                r_wait <= '0;
            end else if ((r_state == ST_MEM_WAIT) && (r_wait != '1)) begin
                r_wait <= r_wait + WAIT_W'(1);
            end
            if ((r_state == ST_INIT) && (r_init_cnt != INIT_CNT_W'(INIT_LAST))) begin
                r_init_cnt <= r_init_cnt + INIT_CNT_W'(1);
            end
            if (w_set_timeout) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign w_cycle_inc = is_active(r_state);
    assign w_stall_inc = w_ctrl[CTL_STALL_IF] && (r_state != ST_HALT);

    pipeline_ctrl_perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .i_inc (w_cycle_inc),
        .o_cnt (cycle_cnt)
    );

    pipeline_ctrl_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .i_inc (w_stall_inc),
        .o_cnt (stall_cnt)
    );

    assign stall_IF    = w_ctrl[CTL_STALL_IF];
    assign stall_ID    = w_ctrl[CTL_STALL_ID];
    assign stall_EX    = w_ctrl[CTL_STALL_EX];
    assign stall_MEM   = w_ctrl[CTL_STALL_MEM];
    assign flush_IF    = w_ctrl[CTL_FLUSH_IF];
    assign flush_ID    = w_ctrl[CTL_FLUSH_ID];
    assign halted      = w_halted;
    assign mem_timeout = r_timeout;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scenario bench for pipeline_ctrl: per-cycle expected control words are queued
// as stimulus is applied and popped when the outputs are sampled.
module tb_pipeline_ctrl;

    localparam int unsigned CNT_W = 8;

    // Control word order: {halted, flush_ID, flush_IF, stall_MEM, stall_EX, stall_ID, stall_IF}
    localparam logic [6:0] C_RUN  = 7'b0_00_0000;
    localparam logic [6:0] C_FL2  = 7'b0_11_0000;
    localparam logic [6:0] C_LU   = 7'b0_10_0001;
    localparam logic [6:0] C_MEMW = 7'b0_00_1111;
    localparam logic [6:0] C_HALT = 7'b1_00_1111;
    localparam logic [6:0] C_RST  = 7'b0_11_1111;

    // Stimulus word order: {run, step, load_use, pc_change, mem_req, mem_ready}
    localparam logic [5:0] I_NONE = 6'b000000;
    localparam logic [5:0] I_RUN  = 6'b100000;
    localparam logic [5:0] I_STEP = 6'b010000;
    localparam logic [5:0] I_LU   = 6'b001000;
    localparam logic [5:0] I_PC   = 6'b000100;
    localparam logic [5:0] I_REQ  = 6'b000010;
    localparam logic [5:0] I_RDY  = 6'b000001;

    typedef struct {
        logic [6:0] ctl;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    logic load_use_hazard, pc_change_EX, mem_req_MEM, mem_ready, run, step;
    logic stall_IF, stall_ID, stall_EX, stall_MEM, flush_IF, flush_ID, halted, mem_timeout;
    logic [CNT_W-1:0] cycle_cnt, stall_cnt;
    logic [6:0] w_act;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(4), .INIT_FLUSH(2)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .load_use_hazard (load_use_hazard),
        .pc_change_EX    (pc_change_EX),
        .mem_req_MEM     (mem_req_MEM),
        .mem_ready       (mem_ready),
        .run             (run),
        .step            (step),
        .stall_IF        (stall_IF),
        .stall_ID        (stall_ID),
        .stall_EX        (stall_EX),
        .stall_MEM       (stall_MEM),
        .flush_IF        (flush_IF),
        .flush_ID        (flush_ID),
        .halted          (halted),
        .mem_timeout     (mem_timeout),
        .cycle_cnt       (cycle_cnt),
        .stall_cnt       (stall_cnt)
    );

    assign w_act = {halted, flush_ID, flush_IF, stall_MEM, stall_EX, stall_ID, stall_IF};

    task automatic apply(input logic [5:0] v, input logic [6:0] e, input string nm);
        {run, step, load_use_hazard, pc_change_EX, mem_req_MEM, mem_ready} = v;
        sb.push_back('{ctl: e, name: nm});
    endtask

    task automatic test_reset();
        exp_t e;
        logic [5:0] in_v [4];
        logic [6:0] ex_v [4];
        rstn = 1'b0;
        {run, step, load_use_hazard, pc_change_EX, mem_req_MEM, mem_ready} = I_RUN;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            apply(I_RUN, C_RST, "reset_ctl");
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (w_act !== e.ctl || cycle_cnt !== '0 || stall_cnt !== '0 || mem_timeout !== 1'b0) begin
                n_err++;
                $display("FAIL %s[%0d]: got ctl=%b cyc=%0d stl=%0d to=%b, want ctl=%b cyc=0 stl=0 to=0",
                         e.name, k, w_act, cycle_cnt, stall_cnt, mem_timeout, e.ctl);
            end
            @(posedge clk); #1;
        end
        rstn = 1'b1;
        in_v = '{I_RUN, I_RUN, I_RUN, I_RUN};
        ex_v = '{C_FL2, C_FL2, C_RUN, C_RUN};
        for (int k = 0; k < 4; k++) begin
            apply(in_v[k], ex_v[k], "init_seq");
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (w_act !== e.ctl) begin
                n_err++;
                $display("FAIL %s[%0d]: got %b want %b", e.name, k, w_act, e.ctl);
            end
            if (k >= 2) begin
                n_cmp++;
                if (cycle_cnt !== CNT_W'(k - 2) || stall_cnt !== '0) begin
                    n_err++;
                    $display("FAIL init_cnt[%0d]: got cyc=%0d stl=%0d want cyc=%0d stl=0",
                             k, cycle_cnt, stall_cnt, k - 2);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_hazards();
        exp_t e;
        logic [CNT_W-1:0] sc0;
        logic [5:0] in_v [6];
        logic [6:0] ex_v [6];
        in_v = '{I_RUN | I_LU, I_RUN, I_RUN | I_LU | I_PC, I_RUN | I_PC, I_RUN, I_RUN | I_LU};
        ex_v = '{C_LU, C_RUN, C_FL2, C_FL2, C_RUN, C_LU};
        sc0 = stall_cnt;
        for (int k = 0; k < 6; k++) begin
            apply(in_v[k], ex_v[k], "hazard");
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (w_act !== e.ctl) begin
                n_err++;
                $display("FAIL %s[%0d]: got %b want %b", e.name, k, w_act, e.ctl);
            end
            if (k == 2) begin
                n_cmp++;
                if (stall_cnt !== sc0 + CNT_W'(1)) begin
                    n_err++;
                    $display("FAIL lu_stall_cnt: got %0d want %0d", stall_cnt, sc0 + CNT_W'(1));
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        exp_t e;
        logic [CNT_W-1:0] sc0;
        logic [5:0] in_v [7];
        logic [6:0] ex_v [7];
        in_v = '{I_RUN | I_REQ, I_RUN | I_REQ | I_PC, I_RUN | I_REQ | I_LU, I_RUN | I_REQ,
                 I_RUN | I_REQ | I_RDY, I_RUN, I_RUN};
        ex_v = '{C_MEMW, C_MEMW, C_MEMW, C_MEMW, C_MEMW, C_RUN, C_RUN};
        sc0 = stall_cnt;
        for (int k = 0; k < 7; k++) begin
            apply(in_v[k], ex_v[k], "mem_wait");
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (w_act !== e.ctl) begin
                n_err++;
                $display("FAIL %s[%0d]: got %b want %b", e.name, k, w_act, e.ctl);
            end
            if (k == 6) begin
                n_cmp++;
                if (stall_cnt !== sc0 + CNT_W'(5) || mem_timeout !== 1'b0) begin
                    n_err++;
                    $display("FAIL mem_stall_cnt: got stl=%0d to=%b want stl=%0d to=0",
                             stall_cnt, mem_timeout, sc0 + CNT_W'(5));
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_halt_step();
        exp_t e;
        logic [CNT_W-1:0] cc0, sc0;
        logic [5:0] in_v [16];
        logic [6:0] ex_v [16];
        in_v = '{I_NONE, I_NONE, I_STEP, I_NONE, I_STEP, I_NONE, I_STEP, I_NONE,
                 I_NONE, I_STEP, I_REQ, I_REQ | I_RDY, I_NONE, I_RUN | I_STEP, I_RUN, I_RUN};
        ex_v = '{C_RUN, C_HALT, C_HALT, C_RUN, C_HALT, C_RUN, C_HALT, C_RUN,
                 C_HALT, C_HALT, C_MEMW, C_MEMW, C_HALT, C_HALT, C_RUN, C_RUN};
        cc0 = '0;
        sc0 = '0;
        for (int k = 0; k < 16; k++) begin
            apply(in_v[k], ex_v[k], "halt_step");
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (w_act !== e.ctl) begin
                n_err++;
                $display("FAIL %s[%0d]: got %b want %b", e.name, k, w_act, e.ctl);
            end
            if (k == 1) begin
                cc0 = cycle_cnt;
                sc0 = stall_cnt;
            end
            if (k == 8) begin
                n_cmp++;
                if (cycle_cnt !== cc0 + CNT_W'(3) || stall_cnt !== sc0) begin
                    n_err++;
                    $display("FAIL step_counts: got cyc=%0d stl=%0d want cyc=%0d stl=%0d",
                             cycle_cnt, stall_cnt, cc0 + CNT_W'(3), sc0);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturation();
        logic [CNT_W-1:0] sc0;
        sc0 = stall_cnt;
        {run, step, load_use_hazard, pc_change_EX, mem_req_MEM, mem_ready} = I_RUN;
        repeat (300) @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if (cycle_cnt !== {CNT_W{1'b1}} || stall_cnt !== sc0) begin
            n_err++;
            $display("FAIL counter_sat: got cyc=%0d stl=%0d want cyc=%0d stl=%0d",
                     cycle_cnt, stall_cnt, {CNT_W{1'b1}}, sc0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        exp_t e;
        logic [5:0] in_v [9];
        logic [6:0] ex_v [9];
        in_v = '{I_RUN | I_REQ, I_RUN | I_REQ, I_RUN | I_REQ, I_RUN | I_REQ, I_RUN | I_REQ,
                 I_RUN | I_REQ, I_RUN, I_RUN, I_RUN | I_STEP};
        ex_v = '{C_MEMW, C_MEMW, C_MEMW, C_MEMW, C_MEMW, C_HALT, C_HALT, C_HALT, C_HALT};
        for (int k = 0; k < 9; k++) begin
            apply(in_v[k], ex_v[k], "timeout");
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (w_act !== e.ctl || mem_timeout !== (k >= 5)) begin
                n_err++;
                $display("FAIL %s[%0d]: got ctl=%b to=%b want ctl=%b to=%b",
                         e.name, k, w_act, mem_timeout, e.ctl, (k >= 5));
            end
            @(posedge clk); #1;
        end
        rstn = 1'b0;
        apply(I_RUN, C_RST, "timeout_rst");
        @(negedge clk);
        e = sb.pop_front();
        n_cmp++;
        if (w_act !== e.ctl) begin
            n_err++;
            $display("FAIL %s: got %b want %b", e.name, w_act, e.ctl);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (mem_timeout !== 1'b0 || cycle_cnt !== '0) begin
            n_err++;
            $display("FAIL timeout_clear: got to=%b cyc=%0d want to=0 cyc=0", mem_timeout, cycle_cnt);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        apply(I_RUN, C_FL2, "post_rst_init");
        @(negedge clk);
        e = sb.pop_front();
        n_cmp++;
        if (w_act !== e.ctl) begin
            n_err++;
            $display("FAIL %s: got %b want %b", e.name, w_act, e.ctl);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_hazards();
        test_mem_wait();
        test_halt_step();
        test_saturation();
        test_timeout();
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
